// File: rtl/bus_master_arbiter.sv
// ---------------------------------------------------------------------------
// bus_master_arbiter: round-robin share of one downstream bus port, one
// transaction in flight. Optional watchdog via ARB_TIMEOUT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bus_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_read,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
  input  logic [NUM_REQ*4-1:0]        req_byte_enable,
  input  logic [NUM_REQ*DATA_W-1:0]   req_writedata,
  output logic [DATA_W-1:0]           req_readdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        bus_read,
  output logic                        bus_write,
  output logic [ADDR_W-1:0]           bus_address,
  output logic [3:0]                  bus_byte_enable,
  output logic [DATA_W-1:0]           bus_writedata,
  input  logic [DATA_W-1:0]           bus_readdata,
  input  logic                        bus_ready,
  output logic [$clog2(NUM_REQ)-1:0]  arb_grant,
  output logic                        arb_busy,
  output logic                        arb_timeout
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] last;
  logic             lat_rd;
  logic             lat_wr;
  logic             found;
  logic [IDX_W-1:0] pick;

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("bus_master_arbiter: unsupported parameter values");
  end

  // First pending requester searching from last+1 upward, wrapping.
  always_comb begin : p_rr
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && (req_read[idx] || req_write[idx])) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
  end

  // Strobes fall in the ready cycle so the slave never sees a second request.
  assign bus_read  = (state == BUSY) && lat_rd && !bus_ready;
  assign bus_write = (state == BUSY) && lat_wr && !bus_ready;
  assign arb_busy  = (state != IDLE);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES) + 1 : 8;
  logic [CNT_W-1:0] cnt;
`else
  assign arb_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      last            <= IDX_W'(NUM_REQ - 1);
      arb_grant       <= '0;
      lat_rd          <= 1'b0;
      lat_wr          <= 1'b0;
      bus_address     <= '0;
      bus_byte_enable <= '0;
      bus_writedata   <= '0;
      req_readdata    <= '0;
      req_ready       <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt             <= '0;
      arb_timeout     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            // Simultaneous read and write is served as a write.
            lat_wr          <= req_write[pick];
            lat_rd          <= req_read[pick] && !req_write[pick];
            bus_address     <= req_address[pick*ADDR_W +: ADDR_W];
            bus_byte_enable <= req_byte_enable[pick*4 +: 4];
            bus_writedata   <= req_writedata[pick*DATA_W +: DATA_W];
            arb_grant       <= pick;
            last            <= pick;
            state           <= BUSY;
`ifdef ARB_TIMEOUT_EN
            cnt             <= '0;
`endif
          end
        end
        BUSY: begin
          if (bus_ready) begin
            if (lat_rd) begin
              req_readdata <= bus_readdata;
            end
            req_ready <= NUM_REQ'(1) << arb_grant;
            state     <= RESP;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            req_readdata <= DATA_W'(32'hDEADBEEF);
            req_ready    <= NUM_REQ'(1) << arb_grant;
            arb_timeout  <= 1'b1;
            state        <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          req_ready <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_master_arbiter: directed checks of arbitration order, bus timing,
// reset abort and watchdog behaviour.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bus_master_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [NUM_REQ-1:0]         req_read = '0;
  logic [NUM_REQ-1:0]         req_write = '0;
  logic [ADDR_W-1:0]          addr [NUM_REQ];
  logic [3:0]                 be   [NUM_REQ];
  logic [DATA_W-1:0]          wd   [NUM_REQ];
  logic [NUM_REQ*ADDR_W-1:0]  req_address;
  logic [NUM_REQ*4-1:0]       req_byte_enable;
  logic [NUM_REQ*DATA_W-1:0]  req_writedata;
  logic [DATA_W-1:0]          req_readdata;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       bus_read;
  logic                       bus_write;
  logic [ADDR_W-1:0]          bus_address;
  logic [3:0]                 bus_byte_enable;
  logic [DATA_W-1:0]          bus_writedata;
  logic [DATA_W-1:0]          bus_readdata = '0;
  logic                       bus_ready = 1'b0;
  logic [$clog2(NUM_REQ)-1:0] arb_grant;
  logic                       arb_busy;
  logic                       arb_timeout;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] model_rdata = '0;

  assign req_address     = {addr[1], addr[0]};
  assign req_byte_enable = {be[1], be[0]};
  assign req_writedata   = {wd[1], wd[0]};

  always #5 clk = ~clk;

  bus_master_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_read(req_read), .req_write(req_write),
    .req_address(req_address), .req_byte_enable(req_byte_enable),
    .req_writedata(req_writedata), .req_readdata(req_readdata),
    .req_ready(req_ready),
    .bus_read(bus_read), .bus_write(bus_write), .bus_address(bus_address),
    .bus_byte_enable(bus_byte_enable), .bus_writedata(bus_writedata),
    .bus_readdata(bus_readdata), .bus_ready(bus_ready),
    .arb_grant(arb_grant), .arb_busy(arb_busy), .arb_timeout(arb_timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered one cycle before the expected BUSY cycle; leaves in the IDLE cycle after RESP.
  task automatic serve(input int g, input bit is_wr, input logic [31:0] rd, input bit rereq);
    @(negedge clk);
    check("busy", 64'(arb_busy), 64'd1);
    check("grant", 64'(arb_grant), 64'(g));
    check("bus_read", 64'(bus_read), 64'(!is_wr));
    check("bus_write", 64'(bus_write), 64'(is_wr));
    check("bus_address", 64'(bus_address), 64'(addr[g]));
    check("bus_byte_enable", 64'(bus_byte_enable), 64'(be[g]));
    check("bus_writedata", 64'(bus_writedata), 64'(wd[g]));
    bus_ready    = 1'b1;
    bus_readdata = rd;
    #1;
    check("strobe_drop", 64'({bus_read, bus_write}), 64'd0);
    @(negedge clk);
    if (!is_wr) model_rdata = rd;
    check("req_ready", 64'(req_ready), 64'd1 << g);
    check("req_readdata", 64'(req_readdata), 64'(model_rdata));
    check("resp_strobes", 64'({bus_read, bus_write}), 64'd0);
    bus_ready    = 1'b0;
    bus_readdata = '0;
    req_read[g]  = 1'b0;
    req_write[g] = 1'b0;
    @(negedge clk);
    check("idle_gap", 64'({arb_busy, req_ready, bus_read, bus_write}), 64'd0);
    if (rereq) req_read[g] = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    addr[0] = 10'h010; addr[1] = 10'h000;
    be[0]   = 4'hF;    be[1]   = 4'hF;
    wd[0]   = '0;      wd[1]   = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({bus_read, bus_write, arb_busy, arb_grant, req_ready, arb_timeout}), 64'd0);
    check("reset_bus_addr", 64'(bus_address), 64'd0);
    check("reset_readdata", 64'(req_readdata), 64'd0);
    rst_n = 1'b1;

    // 1: single read from requester 0
    @(negedge clk);
    req_read[0] = 1'b1;
    serve(0, 1'b0, 32'h12345678, 1'b0);

    // 2: both write from reset; requester 0 first, then 1, with an idle gap
    @(negedge clk);
    rst_n = 1'b0;
    model_rdata = '0;
    addr[0] = 10'h020; addr[1] = 10'h044;
    wd[0] = 32'h11111111; wd[1] = 32'h22222222;
    req_write = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    serve(0, 1'b1, 32'h0, 1'b0);
    serve(1, 1'b1, 32'h0, 1'b0);

    // 3: requester 0 re-requests back-to-back while 1 stays pending
    req_read = 2'b11;
    serve(0, 1'b0, 32'hA1A1A1A1, 1'b1);
    serve(1, 1'b0, 32'hA2A2A2A2, 1'b1);
    serve(0, 1'b0, 32'hA3A3A3A3, 1'b1);
    serve(1, 1'b0, 32'hA4A4A4A4, 1'b0);
    serve(0, 1'b0, 32'hA5A5A5A5, 1'b0);

    // 4: write from requester 1 with read also high; readdata must not change
    addr[0] = 10'h3FF; be[0] = 4'b1100; wd[0] = 32'h0F0F0F0F;
    addr[1] = 10'h094; be[1] = 4'b0011; wd[1] = 32'hAABBCCDD;
    req_write[1] = 1'b1;
    req_read[1]  = 1'b1;
    serve(1, 1'b1, 32'h5555AAAA, 1'b0);

    // 5: reset mid-BUSY aborts; requester 0 wins after release
    addr[1] = 10'h03C;
    req_read[1] = 1'b1;
    @(negedge clk);
    check("pre_abort_busy", 64'({arb_busy, arb_grant, bus_read}), 64'b111);
    rst_n = 1'b0;
    #1;
    check("abort_ctrl", 64'({bus_read, bus_write, arb_busy, arb_grant, req_ready, arb_timeout}), 64'd0);
    check("abort_bus", 64'({bus_address, bus_byte_enable}), 64'd0);
    check("abort_data", 64'({bus_writedata, req_readdata}), 64'd0);
    model_rdata = '0;
    req_read = 2'b11;
    @(negedge clk);
    check("abort_no_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;
    serve(0, 1'b0, 32'h0BADF00D, 1'b0);
    serve(1, 1'b0, 32'h600DCAFE, 1'b0);

    // 6: bus_ready held low for 64 BUSY cycles
    addr[0] = 10'h2A0;
    req_read[0] = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      check("stall_busy", 64'({arb_busy, req_ready}), 64'b100);
    end
`ifdef ARB_TIMEOUT_EN
    @(negedge clk);
    check("timeout_ready", 64'(req_ready), 64'd1);
    check("timeout_data", 64'(req_readdata), 64'hDEADBEEF);
    check("timeout_flag", 64'(arb_timeout), 64'd1);
    check("timeout_strobe", 64'(bus_read), 64'd0);
    req_read[0] = 1'b0;
    @(negedge clk);
    check("timeout_sticky", 64'({arb_timeout, arb_busy}), 64'b10);
`else
    check("no_timeout_flag", 64'(arb_timeout), 64'd0);
    check("still_reading", 64'(bus_read), 64'd1);
    serve(0, 1'b0, 32'hCAFEF00D, 1'b0);
    check("no_timeout_after", 64'(arb_timeout), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
